// File: rtl/color_sampler_pkg.sv
// Shared types and helpers for the window-averaging colour sampler.
package color_sampler_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int COORD_W = 12;

    // Wide enough that W*W samples of full-scale DW-bit data cannot overflow.
    function automatic int acc_width(input int dw, input int win_log2);
        return dw + 2 * win_log2;
    endfunction

    function automatic logic [COORD_W-1:0] win_lo(input logic [COORD_W-1:0] center,
                                                   input logic [COORD_W-1:0] half);
        return (center >= half) ? center - half : '0;
    endfunction

endpackage

// File: rtl/color_sampler_win_chan_accum.sv
// One colour channel: window accumulator, round-half-up average and output register.
// COLOR_SAMPLER_RANGE_EN adds per-channel min/max trackers and their output registers.
module chan_accum
    import color_sampler_pkg::*;
#(
    parameter int DW       = 8,
    parameter int WIN_LOG2 = 2
) (
    input  logic          clk_100M,
    input  logic          rst_p,
    input  logic          i_clear,
    input  logic          i_accum,
    input  logic          i_load,
    input  logic [DW-1:0] i_data,
`ifdef COLOR_SAMPLER_RANGE_EN
    output logic [DW-1:0] o_min,
    output logic [DW-1:0] o_max,
`endif
    output logic [DW-1:0] o_avg
);

    localparam int ACC_W = acc_width(DW, WIN_LOG2);
    localparam int SH    = 2 * WIN_LOG2;
    localparam logic [ACC_W-1:0] HALF = ACC_W'(1) << (SH - 1);

    logic [ACC_W-1:0] r_acc;
    logic [DW-1:0]    r_avg;
    logic [DW-1:0]    w_avg;

    assign w_avg = DW'((r_acc + HALF) >> SH);
    assign o_avg = r_avg;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_100M or posedge rst_p) begin
        if (rst_p) begin
            r_acc <= '0;
            r_avg <= '0;
        end else begin
            if (i_clear)
                r_acc <= '0;
            else if (i_accum)
                r_acc <= r_acc + ACC_W'(i_data);
            if (i_load)
                r_avg <= w_avg;
        end
    end

`ifdef COLOR_SAMPLER_RANGE_EN
    logic [DW-1:0] r_min_run;
    logic [DW-1:0] r_max_run;
    logic [DW-1:0] r_min;
    logic [DW-1:0] r_max;

    assign o_min = r_min;
    assign o_max = r_max;

    // Running trackers start at the opposite extremes so the first pixel always wins.
    always_ff @(posedge clk_100M or posedge rst_p) begin
        if (rst_p) begin
            r_min_run <= '1;
            r_max_run <= '0;
            r_min     <= '0;
            r_max     <= '0;
        end else begin
            if (i_clear) begin
                r_min_run <= '1;
                r_max_run <= '0;
            end else if (i_accum) begin
                if (i_data < r_min_run) r_min_run <= i_data;
                if (i_data > r_max_run) r_max_run <= i_data;
            end
            if (i_load) begin
                r_min <= r_min_run;
                r_max <= r_max_run;
            end
        end
    end
`else
`endif

endmodule

// File: rtl/color_sampler_win.sv
// Window-averaging colour sampler: averages a W x W window around a latched centre once per frame.
// Optional COLOR_SAMPLER_RANGE_EN adds sample_min/sample_max outputs.
module color_sampler_win
    import color_sampler_pkg::*;
#(
    parameter int CH       = 2,
    parameter int DW       = 8,
    parameter int WIN_LOG2 = 2
) (
    input  logic               clk_100M,
    input  logic               rst_p,
    input  logic               en,
    input  logic               frame_start,
    input  logic               pix_valid,
    input  logic [11:0]        pixel_x,
    input  logic [11:0]        pixel_y,
    input  logic [CH*DW-1:0]   pix_data,
    input  logic [11:0]        center_x,
    input  logic [11:0]        center_y,
    output logic [CH*DW-1:0]   sample,
`ifdef COLOR_SAMPLER_RANGE_EN
    output logic [CH*DW-1:0]   sample_min,
    output logic [CH*DW-1:0]   sample_max,
`endif
    output logic               sample_valid,
    output logic               miss,
    output logic               busy
);

    localparam int W     = 1 << WIN_LOG2;
    localparam int W2    = 1 << (2 * WIN_LOG2);
    localparam int CNT_W = 2 * WIN_LOG2 + 1;
    localparam logic [COORD_W-1:0] W_HALF = COORD_W'(W / 2);
    localparam logic [COORD_W:0]   W_SPAN = (COORD_W + 1)'(W - 1);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(W2 - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [COORD_W-1:0] r_x0;
    logic [COORD_W-1:0] r_y0;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_sample_valid;
    logic               r_miss;
    logic               r_busy;

    logic               w_latch;
    logic               w_clear;
    logic               w_accum;
    logic               w_load;
    logic               w_miss;
    logic               w_in_win;
    logic [COORD_W:0]   w_x1;
    logic [COORD_W:0]   w_y1;

    // Upper bounds carry an extra bit so a window near 4095 does not wrap.
    assign w_x1 = {1'b0, r_x0} + W_SPAN;
    assign w_y1 = {1'b0, r_y0} + W_SPAN;
    assign w_in_win = (pixel_x >= r_x0) && ({1'b0, pixel_x} <= w_x1) &&
                      (pixel_y >= r_y0) && ({1'b0, pixel_y} <= w_y1);

    always_ff @(posedge clk_100M or posedge rst_p) begin
        if (rst_p) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_clear     = 1'b0;
        w_accum     = 1'b0;
        w_load      = 1'b0;
        w_miss      = 1'b0;
        case (r_state)
            IDLE: begin
                if (en && frame_start) begin
                    w_latch     = 1'b1;
                    w_clear     = 1'b1;
                    w_state_nxt = ARM;
                end
            end
            ARM: begin
                if (!en) begin
                    w_clear     = 1'b1;
                    w_state_nxt = IDLE;
                end else if (frame_start) begin
                    w_miss  = 1'b1;
                    w_latch = 1'b1;
                    w_clear = 1'b1;
                end else if (pix_valid && w_in_win) begin
                    w_accum = 1'b1;
                    if (r_cnt == CNT_LAST) w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_load      = en;
                w_clear     = !en;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_100M or posedge rst_p) begin
        if (rst_p) begin
            r_x0           <= '0;
            r_y0           <= '0;
            r_cnt          <= '0;
            r_sample_valid <= 1'b0;
            r_miss         <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            if (w_latch) begin
                r_x0 <= win_lo(center_x, W_HALF);
                r_y0 <= win_lo(center_y, W_HALF);
            end
            if (w_clear)
                r_cnt <= '0;
            else if (w_accum)
                r_cnt <= r_cnt + 1'b1;
            r_sample_valid <= w_load;
            r_miss         <= w_miss;
            r_busy         <= (w_state_nxt != IDLE);
        end
    end

    assign sample_valid = r_sample_valid;
    assign miss         = r_miss;
    assign busy         = r_busy;

    // Channel 0 occupies the MSBs of both pix_data and sample.
    for (genvar c = 0; c < CH; c++) begin : g_chan
        localparam int LSB = (CH - 1 - c) * DW;
`ifdef COLOR_SAMPLER_RANGE_EN
        chan_accum #(.DW(DW), .WIN_LOG2(WIN_LOG2)) u_accum (
            .clk_100M (clk_100M),
            .rst_p    (rst_p),
            .i_clear  (w_clear),
            .i_accum  (w_accum),
            .i_load   (w_load),
            .i_data   (pix_data[LSB +: DW]),
            .o_min    (sample_min[LSB +: DW]),
            .o_max    (sample_max[LSB +: DW]),
            .o_avg    (sample[LSB +: DW])
        );
`else
        chan_accum #(.DW(DW), .WIN_LOG2(WIN_LOG2)) u_accum (
            .clk_100M (clk_100M),
            .rst_p    (rst_p),
            .i_clear  (w_clear),
            .i_accum  (w_accum),
            .i_load   (w_load),
            .i_data   (pix_data[LSB +: DW]),
            .o_avg    (sample[LSB +: DW])
        );
`endif
    end

endmodule

// File: tb/tb_color_sampler_win.sv
// Directed self-checking bench for color_sampler_win (default 2 x 8-bit channels, 4x4 window).
// Extra min/max checks are compiled in when COLOR_SAMPLER_RANGE_EN is defined.
module tb_color_sampler_win;

    logic        clk_100M = 1'b0;
    logic        rst_p;
    logic        en;
    logic        frame_start;
    logic        pix_valid;
    logic [11:0] pixel_x;
    logic [11:0] pixel_y;
    logic [15:0] pix_data;
    logic [11:0] center_x;
    logic [11:0] center_y;
    logic [15:0] sample;
`ifdef COLOR_SAMPLER_RANGE_EN
    logic [15:0] sample_min;
    logic [15:0] sample_max;
`endif
    logic        sample_valid;
    logic        miss;
    logic        busy;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk_100M = ~clk_100M;

    color_sampler_win #(.CH(2), .DW(8), .WIN_LOG2(2)) dut (
        .clk_100M     (clk_100M),
        .rst_p        (rst_p),
        .en           (en),
        .frame_start  (frame_start),
        .pix_valid    (pix_valid),
        .pixel_x      (pixel_x),
        .pixel_y      (pixel_y),
        .pix_data     (pix_data),
        .center_x     (center_x),
        .center_y     (center_y),
        .sample       (sample),
`ifdef COLOR_SAMPLER_RANGE_EN
        .sample_min   (sample_min),
        .sample_max   (sample_max),
`endif
        .sample_valid (sample_valid),
        .miss         (miss),
        .busy         (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_100M);
        #1;
    endtask

    task automatic pix(input int x, input int y, input logic [15:0] d);
        pix_valid = 1'b1;
        pixel_x   = 12'(x);
        pixel_y   = 12'(y);
        pix_data  = d;
        tick();
        pix_valid = 1'b0;
    endtask

    task automatic fstart(input int cx, input int cy);
        center_x    = 12'(cx);
        center_y    = 12'(cy);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    function automatic logic [15:0] win_data(input int mode, input int k);
        case (mode)
            0:       return 16'h8040;
            1:       return {8'(k), 8'hFF};
            default: return {8'(16 + k), 8'(255 - k)};
        endcase
    endfunction

    // Raster scan around a 4x4 window at (x0,y0) with stray pixels and idle gaps;
    // stops right after `limit` window pixels have been presented.
    task automatic stream(input int x0, input int y0, input int mode, input int limit);
        int  k    = 0;
        bit  stop = 1'b0;
        bit  in_w;
        pix(x0, y0 + 4, 16'h0000);
        for (int y = y0 - 1; y <= y0 + 3 && !stop; y++) begin
            for (int x = x0 - 2; x <= x0 + 5 && !stop; x++) begin
                in_w = (x >= x0) && (x <= x0 + 3) && (y >= y0) && (y <= y0 + 3);
                if ((x + y) % 5 == 0) tick();
                pix(x, y, in_w ? win_data(mode, k) : 16'h0000);
                if (in_w) k++;
                if (k == limit) stop = 1'b1;
            end
        end
    endtask

    // Called right after the edge that accepted the 16th pixel.
    task automatic finish_window(input string tag, input logic [15:0] exp);
        check({tag, "_pre_valid"}, 32'(sample_valid), 32'd0);
        check({tag, "_pre_busy"}, 32'(busy), 32'd1);
        tick();
        check({tag, "_valid"}, 32'(sample_valid), 32'd1);
        check({tag, "_sample"}, 32'(sample), 32'(exp));
        tick();
        check({tag, "_post_valid"}, 32'(sample_valid), 32'd0);
        check({tag, "_post_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst_p       = 1'b1;
        en          = 1'b0;
        frame_start = 1'b0;
        pix_valid   = 1'b0;
        pixel_x     = '0;
        pixel_y     = '0;
        pix_data    = '0;
        center_x    = '0;
        center_y    = '0;
        tick();
        tick();
        check("rst_sample", 32'(sample), 32'd0);
        check("rst_valid", 32'(sample_valid), 32'd0);
        check("rst_miss", 32'(miss), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
`ifdef COLOR_SAMPLER_RANGE_EN
        check("rst_min", 32'(sample_min), 32'd0);
        check("rst_max", 32'(sample_max), 32'd0);
`endif
        rst_p = 1'b0;
        en    = 1'b1;
        tick();

        // Constant colour over window 158..161 x 118..121.
        fstart(160, 120);
        check("arm_busy", 32'(busy), 32'd1);
        stream(158, 118, 0, 16);
        finish_window("const", 16'h8040);

        // Cr ramp 0..15, Cb 0xFF: Cr (120+8)>>4 = 8, Cb (4080+8)>>4 = 255.
        fstart(160, 120);
        stream(158, 118, 1, 16);
        finish_window("ramp", 16'h08FF);

        // Window 317..320 x 237..240 cannot complete inside a 320x240 frame.
        fstart(319, 239);
        for (int y = 237; y <= 239; y++)
            for (int x = 317; x <= 319; x++)
                pix(x, y, 16'h4444);
        tick();
        tick();
        check("edge_no_valid", 32'(sample_valid), 32'd0);
        check("edge_busy", 32'(busy), 32'd1);
        fstart(160, 120);
        check("edge_miss", 32'(miss), 32'd1);
        check("edge_sample_held", 32'(sample), 32'h08FF);
        tick();
        check("edge_miss_clear", 32'(miss), 32'd0);
        stream(158, 118, 0, 16);
        finish_window("relatch", 16'h8040);

        // Asynchronous reset after 7 ramp pixels, then a clean constant window.
        fstart(160, 120);
        stream(158, 118, 1, 7);
        rst_p = 1'b1;
        #1;
        check("mid_rst_sample", 32'(sample), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_valid", 32'(sample_valid), 32'd0);
        check("mid_rst_miss", 32'(miss), 32'd0);
        tick();
        rst_p = 1'b0;
        tick();
        fstart(160, 120);
        stream(158, 118, 0, 16);
        finish_window("after_rst", 16'h8040);

        // Enable dropped after 10 pixels, restored before the next frame.
        fstart(160, 120);
        stream(158, 118, 1, 10);
        en = 1'b0;
        tick();
        check("en_drop_busy", 32'(busy), 32'd0);
        check("en_drop_valid", 32'(sample_valid), 32'd0);
        en = 1'b1;
        tick();
        check("en_drop_sample", 32'(sample), 32'h8040);
        check("en_drop_miss", 32'(miss), 32'd0);
        fstart(160, 120);
        stream(158, 118, 1, 16);
        finish_window("after_en", 16'h08FF);

        // frame_start wins over a coincident in-window pixel.
        fstart(160, 120);
        center_x    = 12'd160;
        center_y    = 12'd120;
        frame_start = 1'b1;
        pix_valid   = 1'b1;
        pixel_x     = 12'd158;
        pixel_y     = 12'd118;
        pix_data    = 16'hFFFF;
        tick();
        frame_start = 1'b0;
        pix_valid   = 1'b0;
        check("prio_miss", 32'(miss), 32'd1);
        stream(158, 118, 0, 16);
        finish_window("prio", 16'h8040);

        // Cr 0x10..0x1F, Cb 0xFF..0xF0: Cr (376+8)>>4 = 0x18, Cb (3960+8)>>4 = 0xF8.
        fstart(160, 120);
        stream(158, 118, 2, 16);
        check("range_pre_valid", 32'(sample_valid), 32'd0);
`ifdef COLOR_SAMPLER_RANGE_EN
        check("range_pre_min", 32'(sample_min), 32'h8040);
        check("range_pre_max", 32'(sample_max), 32'h8040);
`endif
        tick();
        check("range_valid", 32'(sample_valid), 32'd1);
        check("range_sample", 32'(sample), 32'h18F8);
`ifdef COLOR_SAMPLER_RANGE_EN
        check("range_min", 32'(sample_min), 32'h10F0);
        check("range_max", 32'(sample_max), 32'h1FFF);
`endif
        tick();
        check("range_post_valid", 32'(sample_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/color_sampler_win.md
# color_sampler_win

Parametrised window-averaging colour sampler for the ball locator's pixel stream. It averages an N-channel pixel value over a square window centred on a run-time selectable coordinate, once per frame, and publishes the averaged sample with a one-cycle valid strobe. The downstream colour-threshold logic uses this sample as its reference colour. It replaces the fixed single-point, fixed-2-channel sampler.

## Interface
- CH, 2: number of channels in `pix_data` (e.g. Cr, Cb)
- DW, 8: bits per channel
- WIN_LOG2, 2: log2 of window side W; window is W×W pixels (default 4×4 = 16)
- clk_100M  in  1  system clock
- rst_p  in  1  reset; asynchronous, active-high
- en  in  1  sampler enable
- frame_start  in  1  one-cycle pulse at the start of each frame
- pix_valid  in  1  `pix_data`, `pixel_x` and `pixel_y` are valid this cycle
- pixel_x  in  12  column of the current pixel
- pixel_y  in  12  row of the current pixel
- pix_data  in  CH*DW  packed pixel; channel 0 in the MSBs
- center_x  in  12  window centre column; latched on `frame_start`
- center_y  in  12  window centre row; latched on `frame_start`
- sample  out  CH*DW  averaged pixel; same packing as `pix_data`
- sample_valid  out  1  one-cycle strobe when `sample` updates
- miss  out  1  one-cycle strobe when a window was left incomplete
- busy  out  1  high while in ARM or DONE

## Operation
- Window bounds: x0 = max(center_x − W/2, 0), x1 = x0 + W − 1. y0 and y1 are derived the same way from center_y. Bounds are computed from the centre latched on `frame_start`.
- A pixel is accepted when all of these hold: state is ARM, `pix_valid` is 1, x0 ≤ `pixel_x` ≤ x1, and y0 ≤ `pixel_y` ≤ y1.
- Accumulators: one per channel, width DW+2·WIN_LOG2, so they cannot overflow. A pixel counter of width 2·WIN_LOG2+1 runs alongside them.
- Output per channel = (acc + 2^(2·WIN_LOG2−1)) >> 2·WIN_LOG2, i.e. round half-up. Maximum result is 2^DW−1, so no saturation is needed.
- State IDLE:
  - `frame_start` with `en` = 1: latch the centre, clear accumulators and counter, go to ARM.
- State ARM:
  - Accumulate accepted pixels.
  - When the counter reaches W² (including the last accepted pixel): go to DONE.
  - `frame_start` before the window completes: pulse `miss`, relatch the centre, clear, stay in ARM.
- State DONE:
  - Register the rounded averages into `sample`, pulse `sample_valid`, go to IDLE.
  - A new window is started only by the next `frame_start`, so at most one sample is produced per frame.
- `en` falling in ARM or DONE: abort to IDLE and discard partial sums. `sample` holds its last value and no strobe is issued.
- `frame_start` and `pix_valid` in the same cycle: `frame_start` has priority and that pixel is discarded.
- Window extending beyond the frame: the window never completes, and `miss` pulses on the next `frame_start`.
- `rst_p` mid-window: immediate return to IDLE and all state is cleared.

## Timing
- Reset values: `sample` = 0, `sample_valid` = 0, `miss` = 0, `busy` = 0, state IDLE, accumulators and counter 0.
- Latency: if the last window pixel is accepted at cycle N, `sample` and `sample_valid` change at edge N+2. That is one cycle to enter DONE and one output register stage.
- `miss` rises in the cycle after the offending `frame_start`.
- All outputs are registered. No combinational path exists from inputs to outputs.
- Pixels may arrive on any cycle; `pix_valid` gaps of any length are tolerated.

## Configuration
- COLOR_SAMPLER_RANGE_EN
  - Defined: adds outputs `sample_min` and `sample_max` (each CH*DW). They hold the per-channel minimum and maximum of the accepted window pixels and update with `sample`. Their reset value is 0; the running trackers are cleared on window start.
  - Undefined: these ports and their trackers do not exist, and the remaining behaviour is identical.

## Structure
- Package `color_sampler_pkg`:
  - State enum {IDLE, ARM, DONE}.
  - Function computing accumulator width DW+2·WIN_LOG2.
  - Window-bound clamp function.
- Sub-module `chan_accum`: one per channel, generated CH times. It contains the accumulator, the round/shift logic and, under the macro, the min/max trackers.
- The top level holds the FSM, pixel counter, window compare and output registers.

## Test plan
- Defaults, centre (160,120), constant `pix_data` 0x8040 streamed over a 320×240 frame → window x 158..161, y 118..121; one `sample_valid`; `sample` = 0x8040.
- Window Cr values 0..15 in raster order, Cb = 0xFF → `sample` = 0x08FF (sum 120 + 8, >>4 = 8); strobe at edge N+2 after the 16th pixel.
- Centre (319,239), frame ends at x = 319 → no `sample_valid`; `miss` = 1 one cycle after the next `frame_start`.
- `rst_p` pulsed after 7 accepted pixels → all outputs 0 within the reset; the next full frame yields the correct average with no residue from the aborted window.
- `en` dropped after 10 pixels, then restored before the next `frame_start` → prior `sample` unchanged, no strobe; the following frame produces a fresh sample.
- With COLOR_SAMPLER_RANGE_EN, Cr window values 0x10..0x1F → `sample_min` Cr = 0x10, `sample_max` Cr = 0x1F, both updating with `sample`.
